// File: rtl/rps_match_engine.sv
// Best-of-N stone-paper-scissors match controller: collects one move per player per round,
// judges it, keeps scores, and supports a move timeout and an LFSR-driven CPU opponent.
module rps_match_engine #(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 3,
  parameter int TIMEOUT    = 255,
  parameter int TMR_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [1:0]         p1_move,
  input  logic               p1_valid,
  input  logic [1:0]         p2_move,
  input  logic               p2_valid,
  output logic [1:0]         round_result,
  output logic               result_valid,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         match_winner,
  output logic               match_done,
  output logic [1:0]         cpu_move,
  output logic [2:0]         state,
  output logic [2:0]         debug
);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    COLLECT    = 3'b001,
    JUDGE      = 3'b010,
    MATCH_DONE = 3'b011
  } state_t;

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_TARGET);
  localparam logic [TMR_W:0]     TMO = (TMR_W + 1)'(TIMEOUT);

  state_t             cur_state;
  state_t             next_state;
  logic [7:0]         lfsr;
  logic               mode_lat;
  logic               p1_lat;
  logic               p2_lat;
  logic [1:0]         p1_mv;
  logic [1:0]         p2_mv;
  logic [TMR_W-1:0]   timer;

  logic [1:0]         cpu_pick;
  logic               p1_take;
  logic               p2_take;
  logic               timeout_hit;
  logic               do_abort;
  logic [1:0]         res;
  logic [SCORE_W-1:0] p1_next;
  logic [SCORE_W-1:0] p2_next;
  logic               win1;
  logic               win2;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; a nonzero seed never reaches zero.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    lfsr_step = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    if (a == b) begin
      judge = 2'b00;
    end else begin
      case ({a, b})
        4'b00_10, 4'b01_00, 4'b10_01: judge = 2'b01;
        default:                      judge = 2'b10;
      endcase
    end
  endfunction

  assign state      = cur_state;
  assign match_done = (cur_state == MATCH_DONE);
  assign debug      = {mode_lat, p1_lat, p2_lat};

  always_comb begin
    cpu_pick    = (lfsr[1:0] == 2'b11) ? 2'b00 : lfsr[1:0];
    do_abort    = abort && (cur_state != IDLE);
    p1_take     = (cur_state == COLLECT) && !p1_lat && p1_valid && (p1_move != 2'b11);
    p2_take     = (cur_state == COLLECT) && !p2_lat &&
                  (mode_lat || (p2_valid && (p2_move != 2'b11)));
    timeout_hit = (TIMEOUT != 0) && (({1'b0, timer} + {{TMR_W{1'b0}}, 1'b1}) == TMO);
    // A round reaching JUDGE with a player missing was forced by the timeout.
    if (p1_lat && p2_lat) begin
      res = judge(p1_mv, p2_mv);
    end else if (p1_lat) begin
      res = 2'b01;
    end else if (p2_lat) begin
      res = 2'b10;
    end else begin
      res = 2'b00;
    end
    p1_next = p1_score + SCORE_W'(1);
    p2_next = p2_score + SCORE_W'(1);
    win1    = (res == 2'b01) && (p1_next == WIN);
    win2    = (res == 2'b10) && (p2_next == WIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = cur_state;
    if (do_abort) begin
      next_state = IDLE;
    end else begin
      case (cur_state)
        IDLE:       if (start) next_state = COLLECT;
                    else       next_state = IDLE;
        COLLECT:    if (((p1_lat || p1_take) && (p2_lat || p2_take)) || timeout_hit)
                      next_state = JUDGE;
                    else
                      next_state = COLLECT;
        JUDGE:      next_state = (win1 || win2) ? MATCH_DONE : COLLECT;
        MATCH_DONE: if (!start) next_state = IDLE;
                    else        next_state = MATCH_DONE;
        default:    next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr         <= 8'h01;
      mode_lat     <= 1'b0;
      p1_lat       <= 1'b0;
      p2_lat       <= 1'b0;
      p1_mv        <= 2'b00;
      p2_mv        <= 2'b00;
      timer        <= '0;
      round_result <= 2'b00;
      result_valid <= 1'b0;
      p1_score     <= '0;
      p2_score     <= '0;
      match_winner <= 2'b00;
      cpu_move     <= 2'b00;
    end else begin
      lfsr         <= lfsr_step(lfsr);
      result_valid <= 1'b0;
      if (do_abort) begin
        p1_lat       <= 1'b0;
        p2_lat       <= 1'b0;
        timer        <= '0;
        p1_score     <= '0;
        p2_score     <= '0;
        match_winner <= 2'b00;
      end else begin
        case (cur_state)
          IDLE: begin
            round_result <= 2'b00;
            if (start) begin
              mode_lat     <= mode;
              p1_lat       <= 1'b0;
              p2_lat       <= 1'b0;
              timer        <= '0;
              p1_score     <= '0;
              p2_score     <= '0;
              match_winner <= 2'b00;
            end
          end
          COLLECT: begin
            timer <= timer + TMR_W'(1);
            if (p1_take) begin
              p1_lat <= 1'b1;
              p1_mv  <= p1_move;
            end
            if (p2_take) begin
              p2_lat <= 1'b1;
              p2_mv  <= mode_lat ? cpu_pick : p2_move;
              if (mode_lat) cpu_move <= cpu_pick;
            end
          end
          JUDGE: begin
            round_result <= res;
            result_valid <= 1'b1;
            if (res == 2'b01) p1_score <= p1_next;
            if (res == 2'b10) p2_score <= p2_next;
            if (win1) begin
              match_winner <= 2'b01;
            end else if (win2) begin
              match_winner <= 2'b10;
            end else begin
              p1_lat <= 1'b0;
              p2_lat <= 1'b0;
              timer  <= '0;
            end
          end
          MATCH_DONE: begin
            match_winner <= match_winner;
          end
          default: begin
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rps_match_engine.sv
// Self-checking bench for rps_match_engine: table-driven two-player rounds, timeout,
// abort, CPU mode against an independent LFSR model, and reset during JUDGE.
module tb_rps_match_engine;

  localparam int WT = 3;

  logic       clk = 1'b0;
  logic       reset, start, abort, mode;
  logic [1:0] p1_move, p2_move;
  logic       p1_valid, p2_valid;
  logic [1:0] round_result, match_winner, cpu_move;
  logic       result_valid, match_done;
  logic [2:0] p1_score, p2_score, state, debug;

  rps_match_engine #(.WIN_TARGET(WT), .SCORE_W(3), .TIMEOUT(4), .TMR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .p1_move(p1_move), .p1_valid(p1_valid), .p2_move(p2_move), .p2_valid(p2_valid),
    .round_result(round_result), .result_valid(result_valid),
    .p1_score(p1_score), .p2_score(p2_score), .match_winner(match_winner),
    .match_done(match_done), .cpu_move(cpu_move), .state(state), .debug(debug)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] m1; logic [1:0] m2; logic [1:0] res; } vec_t;
  typedef struct { logic [1:0] res; logic [1:0] cpu; bit chk_cpu; } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         s1 = 0, s2 = 0;
  bit         m_done = 1'b0;
  logic [7:0] m_lfsr;
  vec_t       tbl[7];

  // Reference opponent generator, stepped on the same edges as the design.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'h01;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] rps(input logic [1:0] a, input logic [1:0] b);
    if (a == b) return 2'b00;
    if ((a == 2'd0 && b == 2'd2) || (a == 2'd1 && b == 2'd0) || (a == 2'd2 && b == 2'd1))
      return 2'b01;
    return 2'b10;
  endfunction

  task automatic wait_result(output int waited);
    exp_t e;
    bit   got = 1'b0;
    waited = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (result_valid) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL result_timeout: got no result_valid expected a pulse");
      if (sbq.size() != 0) e = sbq.pop_front();
      return;
    end
    if (sbq.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_result: got pulse expected none queued");
      return;
    end
    e = sbq.pop_front();
    if (e.res == 2'b01) s1++;
    if (e.res == 2'b10) s2++;
    m_done = (s1 == WT) || (s2 == WT);
    check("round_result", round_result, e.res);
    check("p1_score", p1_score, s1);
    check("p2_score", p2_score, s2);
    check("match_done", match_done, m_done);
    check("match_winner", match_winner, (s1 == WT) ? 2'b01 : (s2 == WT) ? 2'b10 : 2'b00);
    check("state_after_judge", state, m_done ? 3'b011 : 3'b001);
    if (e.chk_cpu) begin
      check("cpu_move", cpu_move, e.cpu);
      check("cpu_not_11", cpu_move == 2'b11, 1'b0);
    end
  endtask

  task automatic start_match(input logic m);
    start = 1'b1; mode = m;
    @(negedge clk);
    s1 = 0; s2 = 0; m_done = 1'b0;
    check("start_state", state, 3'b001);
    check("start_scores", {p1_score, p2_score}, 6'd0);
    check("start_mode", debug[2], m);
  endtask

  task automatic two_round(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] r);
    int w;
    exp_t e;
    p1_move = m1; p2_move = m2; p1_valid = 1'b1; p2_valid = 1'b1;
    e.res = r; e.cpu = 2'b00; e.chk_cpu = 1'b0;
    sbq.push_back(e);
    @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
    check("state_judge", state, 3'b010);
    wait_result(w);
  endtask

  task automatic end_match();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_done", state, 3'b011);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_to_idle", state, 3'b000);
    check("score_visible", {p1_score, p2_score}, {3'(s1), 3'(s2)});
    @(negedge clk);
    check("idle_clears_result", round_result, 2'b00);
  endtask

  initial begin
    int   w;
    exp_t e;
    logic [1:0] m1, exp_cpu;

    tbl[0] = '{2'd0, 2'd0, 2'b00};
    tbl[1] = '{2'd1, 2'd0, 2'b01};
    tbl[2] = '{2'd0, 2'd1, 2'b10};
    tbl[3] = '{2'd2, 2'd2, 2'b00};
    tbl[4] = '{2'd2, 2'd0, 2'b10};
    tbl[5] = '{2'd0, 2'd2, 2'b01};
    tbl[6] = '{2'd1, 2'd2, 2'b10};

    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    p1_move = 2'd0; p2_move = 2'd0; p1_valid = 1'b0; p2_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", state, 3'b000);
    check("rst_scores", {p1_score, p2_score}, 6'd0);
    check("rst_outs", {round_result, result_valid, match_winner, match_done}, 6'd0);
    check("rst_cpu_debug", {cpu_move, debug}, 5'd0);
    reset = 1'b0;
    @(negedge clk);

    // Scissors beats paper three times in a row.
    start_match(1'b0);
    for (int i = 0; i < 3; i++) two_round(2'd2, 2'd1, 2'b01);
    end_match();

    // Table of two-player rounds ending in a P2 match win.
    start_match(1'b0);
    for (int i = 0; i < 7; i++) two_round(tbl[i].m1, tbl[i].m2, tbl[i].res);
    end_match();

    // Tie, then an invalid P1 move that never latches and times out.
    start_match(1'b0);
    two_round(2'd0, 2'd0, 2'b00);
    p1_move = 2'b11; p1_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0;
    check("invalid_not_latched", debug[1], 1'b0);
    check("invalid_no_judge", state, 3'b001);
    e = '{2'b00, 2'b00, 1'b0}; sbq.push_back(e);
    wait_result(w);
    check("timeout_len_none", w, 4);
    // Only P2 moves: forced P2 win.
    p2_move = 2'd1; p2_valid = 1'b1;
    @(negedge clk);
    p2_valid = 1'b0;
    check("p2_latched", debug[0], 1'b1);
    e = '{2'b10, 2'b00, 1'b0}; sbq.push_back(e);
    wait_result(w);
    check("timeout_len_p2", w, 4);
    // Only P1 moves: forced P1 win.
    p1_move = 2'd0; p1_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0;
    e = '{2'b01, 2'b00, 1'b0}; sbq.push_back(e);
    wait_result(w);
    check("timeout_len_p1", w, 4);
    two_round(2'd1, 2'd0, 2'b01);

    // Abort at 2-1 on the same edge as a final move.
    abort = 1'b1; start = 1'b0;
    p1_move = 2'd0; p2_move = 2'd2; p1_valid = 1'b1; p2_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;
    s1 = 0; s2 = 0;
    check("abort_state", state, 3'b000);
    check("abort_scores", {p1_score, p2_score}, 6'd0);
    check("abort_winner", match_winner, 2'b00);
    check("abort_latches", debug[1:0], 2'b00);
    check("abort_no_pulse", result_valid, 1'b0);
    @(negedge clk);
    check("abort_no_pulse2", result_valid, 1'b0);

    // CPU mode: P2 inputs ignored, mode changes mid-match ignored.
    start_match(1'b1);
    for (int r = 0; r < 100; r++) begin
      m1 = 2'(r % 3);
      exp_cpu = (m_lfsr[1:0] == 2'b11) ? 2'b00 : m_lfsr[1:0];
      p1_move = m1; p1_valid = 1'b1;
      p2_move = 2'd1; p2_valid = r[0];
      mode = r[1];
      e.res = rps(m1, exp_cpu); e.cpu = exp_cpu; e.chk_cpu = 1'b1;
      sbq.push_back(e);
      @(negedge clk);
      p1_valid = 1'b0; p2_valid = 1'b0;
      check("cpu_state_judge", state, 3'b010);
      wait_result(w);
      if (m_done) begin
        start = 1'b0;
        @(negedge clk);
        start_match(1'b1);
      end
    end
    abort = 1'b1; start = 1'b0;
    @(negedge clk);
    abort = 1'b0;

    // Reset asserted while in JUDGE.
    start_match(1'b0);
    p1_move = 2'd0; p2_move = 2'd2; p1_valid = 1'b1; p2_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
    check("pre_reset_judge", state, 3'b010);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_state", state, 3'b000);
    check("midrst_scores", {p1_score, p2_score}, 6'd0);
    check("midrst_outs", {round_result, result_valid, match_winner, match_done}, 6'd0);
    check("midrst_cpu_debug", {cpu_move, debug}, 5'd0);
    @(negedge clk);
    check("midrst_no_pulse", result_valid, 1'b0);
    check("leftover_expect", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
